minmax_stream: RTL and testbench
================================

// Module: minmax_stream
// PURPOSE
//  Streaming min/max tracker: successor to the 4-input min/max selector. Accepts a
//  valid/ready sample stream, tracks running min and max (values and first-occurrence
//  indices) per frame, emits one result per frame. Sits after sample sources, feeding
//  range/peak logic. Frames end on in_last or after MAX_LEN samples.
// PARAMETERS
//  WIDTH   5  sample width (bits)
//  MAX_LEN 16 max samples per frame (>=2); frame force-closed at this count
//  SIGNED  0  1: compare two's-complement; 0: unsigned
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              async reset, active low
//  clr         in   1              sync abort of current frame (result reg untouched)
//  in_valid    in   1              sample valid
//  in_ready    out  1              sample accepted when in_valid&&in_ready
//  in_data     in   WIDTH          sample
//  in_last     in   1              last sample of frame
//  out_valid   out  1              result valid, held until out_ready
//  out_ready   in   1              result consumed when out_valid&&out_ready
//  out_min     out  WIDTH          frame minimum
//  out_max     out  WIDTH          frame maximum
//  out_min_idx out  $clog2(MAX_LEN)   index of first minimum
//  out_max_idx out  $clog2(MAX_LEN)   index of first maximum
//  out_count   out  $clog2(MAX_LEN+1) samples in frame
//  out_forced  out  1              frame closed by MAX_LEN, not in_last
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (rst_n).
//  - Reset: state IDLE, all out_* = 0, out_valid = 0; running min/max/idx/count = 0.
//  - in_ready = !(out_valid && !out_ready) (combinational); 1 out of reset.
//  - FSM: IDLE (no samples yet) -> ACC on accepted sample without close;
//    IDLE/ACC -> IDLE on accepted closing sample (result loaded);
//    any state -> IDLE on clr (clr beats a same-cycle sample; sample dropped).
//  - First sample of frame: min=max=in_data, both idx=0, count=1.
//  - Later samples: update min only if in_data < min (strict), max only if in_data > max
//    (strict) -> ties keep earliest index. Compare per SIGNED.
//  - Close: in_last, or accepted sample is number MAX_LEN (out_forced=1 iff no in_last).
//    Result regs load from running state incl. the closing sample; out_valid=1 the
//    cycle after the closing handshake (latency 1).
//  - Result regs hold stable while out_valid && !out_ready. Same-cycle out handshake and
//    new close: load new result, out_valid stays 1.
//  - Single-sample frame (in_last on first): min=max=sample, idx 0, count 1.
//  - Samples after a close start a fresh frame; no bubble required.
//  - Reset mid-frame discards running state and any pending result.
// STRUCTURE
//  - Package minmax_pkg: state enum {IDLE, ACC}; function less_than(a,b,signed_mode).
//  - Sub-module minmax_cmp #(WIDTH,SIGNED): combinational; outputs lt/gt of sample vs.
//    current min/max. Top holds FSM, counters, running and result registers.
// TESTING
//  - Unsigned, W=5: 3,7,1,7,1(last) -> min=1 idx2, max=7 idx1, count5, forced0.
//  - SIGNED=1, W=5: 5,-3,0,-16(last) -> min=-16(0x10) idx3, max=5 idx0.
//  - MAX_LEN=16, 16 samples 0..15, no in_last -> out_forced=1, count16, max=15 idx15;
//    sample 17 starts new frame (count resets).
//  - out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0; out_ready=1 ->
//    in_ready=1 same cycle, out_valid drops next cycle.
//  - clr after 3 samples, then 9(last) -> result min=max=9, count1; clr with
//    in_valid same cycle -> sample not counted.
//  - rst_n low mid-frame and with pending result -> out_valid=0, outputs 0 asynchronously.

Source files
------------

// File: rtl/minmax_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : minmax_pkg
//  Purpose  : Shared types and helpers for the streaming min/max tracker.
//             - state_t   : frame-tracking state (IDLE = no sample yet, ACC =
//                           at least one sample accumulated in this frame)
//             - less_than : magnitude compare on pre-extended operands, either
//                           two's-complement or unsigned
//  Revision : 1.0 - initial release
// ============================================================================
package minmax_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Common compare width. Callers extend their samples to this width
    // (sign- or zero-extension as appropriate) before calling less_than, so
    // one function serves every sample width up to C_CMP_W bits.
    localparam int C_CMP_W = 32;

    function automatic logic less_than(
        input logic [C_CMP_W-1:0] a,
        input logic [C_CMP_W-1:0] b,
        input logic               signed_mode
    );
        logic r;
        if (signed_mode) begin
            r = ($signed(a) < $signed(b));
        end else begin
            r = (a < b);
        end
        return r;
    endfunction

endpackage : minmax_pkg
`default_nettype wire

// File: rtl/minmax_cmp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : minmax_cmp
//  Purpose  : Combinational comparator of an incoming sample against the
//             current running minimum and maximum.
//  Ports    : sample   in  WIDTH  incoming sample
//             cur_min  in  WIDTH  running minimum
//             cur_max  in  WIDTH  running maximum
//             lt       out 1      sample <  cur_min (strict)
//             gt       out 1      sample >  cur_max (strict)
//  Params   : WIDTH  sample width (<= 32)
//             SIGNED 1: two's-complement compare, 0: unsigned compare
//  Revision : 1.0 - initial release
// ============================================================================
module minmax_cmp #(
    parameter int WIDTH  = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    output logic             lt,
    output logic             gt
);
    import minmax_pkg::*;

    // Extend to the package compare width; the upper bits replicate the sign
    // bit only in signed mode so the signed compare sees the true value.
    function automatic logic [C_CMP_W-1:0] ext(input logic [WIDTH-1:0] v);
        logic [C_CMP_W-1:0] r;
        r            = {C_CMP_W{SIGNED & v[WIDTH-1]}};
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Strict compares: equal values never win, so ties keep the earliest index.
    assign lt = less_than(ext(sample),  ext(cur_min), SIGNED);
    assign gt = less_than(ext(cur_max), ext(sample),  SIGNED);

endmodule : minmax_cmp
`default_nettype wire

// File: rtl/minmax_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : minmax_stream
//  Purpose  : Streaming min/max tracker. Accepts a valid/ready sample stream,
//             tracks the running minimum and maximum (values and index of the
//             first occurrence) of each frame and emits one result per frame.
//             A frame closes on in_last or on its MAX_LEN-th sample.
//  Ports    : clk          in   1        clock, rising edge
//             rst_n        in   1        asynchronous reset, active low
//             clr          in   1        synchronous abort of current frame
//             in_valid     in   1        sample valid
//             in_ready     out  1        sample accepted on in_valid&&in_ready
//             in_data      in   WIDTH    sample
//             in_last      in   1        last sample of frame
//             out_valid    out  1        result valid, held until out_ready
//             out_ready    in   1        result consumed on out_valid&&out_ready
//             out_min      out  WIDTH    frame minimum
//             out_max      out  WIDTH    frame maximum
//             out_min_idx  out  clog2(MAX_LEN)     index of first minimum
//             out_max_idx  out  clog2(MAX_LEN)     index of first maximum
//             out_count    out  clog2(MAX_LEN+1)   samples in frame
//             out_forced   out  1        frame closed by length, not in_last
//  Params   : WIDTH   sample width (<= 32)
//             MAX_LEN maximum samples per frame (>= 2)
//             SIGNED  1: two's-complement compare, 0: unsigned compare
//  Revision : 1.0 - initial release
// ============================================================================
module minmax_stream #(
    parameter int WIDTH   = 5,
    parameter int MAX_LEN = 16,
    parameter bit SIGNED  = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_min,
    output logic [WIDTH-1:0]             out_max,
    output logic [$clog2(MAX_LEN)-1:0]   out_min_idx,
    output logic [$clog2(MAX_LEN)-1:0]   out_max_idx,
    output logic [$clog2(MAX_LEN+1)-1:0] out_count,
    output logic                         out_forced
);
    import minmax_pkg::*;

    localparam int                   C_IDX_W   = $clog2(MAX_LEN);
    localparam int                   C_CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [C_CNT_W-1:0]   C_MAX_CNT = C_CNT_W'(MAX_LEN);

    // ------------------------------------------------------------------------
    // State and running registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_min;
    logic [WIDTH-1:0]     r_max;
    logic [C_IDX_W-1:0]   r_min_idx;
    logic [C_IDX_W-1:0]   r_max_idx;
    logic [C_CNT_W-1:0]   r_count;

    logic                 w_accept;
    logic                 w_first;
    logic                 w_close;
    logic                 w_lt;
    logic                 w_gt;
    logic [C_IDX_W-1:0]   w_idx;
    logic [C_CNT_W-1:0]   w_count_nxt;
    logic [WIDTH-1:0]     w_min_nxt;
    logic [WIDTH-1:0]     w_max_nxt;
    logic [C_IDX_W-1:0]   w_min_idx_nxt;
    logic [C_IDX_W-1:0]   w_max_idx_nxt;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // A sample may only be taken when the result register is free, or is
    // being drained in this same cycle; a closing sample can then overwrite
    // it without losing the previous result.
    assign in_ready = !(out_valid && !out_ready);

    // clr wins over a coincident sample: that sample is dropped.
    assign w_accept = in_valid && in_ready && !clr;

    // ------------------------------------------------------------------------
    // Running min/max datapath
    // ------------------------------------------------------------------------
    assign w_first = (r_state == IDLE);

    // Index of the incoming sample within its frame. In ACC the count is at
    // most MAX_LEN-1, so it always fits the index width.
    assign w_idx       = w_first ? '0 : r_count[C_IDX_W-1:0];
    assign w_count_nxt = w_first ? C_CNT_W'(1) : (r_count + 1'b1);

    assign w_close = w_accept && (in_last || (w_count_nxt == C_MAX_CNT));

    minmax_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .sample  (in_data),
        .cur_min (r_min),
        .cur_max (r_max),
        .lt      (w_lt),
        .gt      (w_gt)
    );

    // On the first sample the running registers hold stale/zero values, so
    // the compare result is ignored and the sample seeds both extremes.
    assign w_min_nxt     = (w_first || w_lt) ? in_data : r_min;
    assign w_max_nxt     = (w_first || w_gt) ? in_data : r_max;
    assign w_min_idx_nxt = (w_first || w_lt) ? w_idx   : r_min_idx;
    assign w_max_idx_nxt = (w_first || w_gt) ? w_idx   : r_max_idx;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_close ? IDLE : ACC;
        end
    end

    // ------------------------------------------------------------------------
    // Running registers: cleared on abort and after every close so each new
    // frame starts from a clean slate.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min     <= '0;
            r_max     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_count   <= '0;
        end else if (clr || w_close) begin
            r_min     <= '0;
            r_max     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_min     <= w_min_nxt;
            r_max     <= w_max_nxt;
            r_min_idx <= w_min_idx_nxt;
            r_max_idx <= w_max_idx_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Result registers. A close is only possible while the result register
    // is free or draining, so loading here never overwrites an unconsumed
    // result. clr leaves these registers alone.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
            out_count   <= '0;
            out_forced  <= 1'b0;
        end else if (w_close) begin
            out_valid   <= 1'b1;
            out_min     <= w_min_nxt;
            out_max     <= w_max_nxt;
            out_min_idx <= w_min_idx_nxt;
            out_max_idx <= w_max_idx_nxt;
            out_count   <= w_count_nxt;
            out_forced  <= !in_last;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule : minmax_stream
`default_nettype wire

// File: tb/tb_minmax_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_minmax_stream
//  Purpose  : Self-checking bench for minmax_stream. An unsigned and a signed
//             instance share every input; a frame-level reference model
//             predicts both results, directed tables and sequences cover the
//             corner cases, and a random phase exercises the handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_minmax_stream;

    localparam int WIDTH   = 5;
    localparam int MAX_LEN = 16;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clr       = 1'b0;
    logic       in_valid  = 1'b0;
    logic [4:0] in_data   = '0;
    logic       in_last   = 1'b0;
    logic       out_ready = 1'b0;

    logic       u_in_ready, u_out_valid, u_out_forced;
    logic [4:0] u_out_min, u_out_max, u_out_count;
    logic [3:0] u_out_min_idx, u_out_max_idx;
    logic       s_in_ready, s_out_valid, s_out_forced;
    logic [4:0] s_out_min, s_out_max, s_out_count;
    logic [3:0] s_out_min_idx, s_out_max_idx;

    always #5 clk = ~clk;

    minmax_stream #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_min(u_out_min), .out_max(u_out_max), .out_min_idx(u_out_min_idx),
        .out_max_idx(u_out_max_idx), .out_count(u_out_count), .out_forced(u_out_forced)
    );

    minmax_stream #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_min(s_out_min), .out_max(s_out_max), .out_min_idx(s_out_min_idx),
        .out_max_idx(s_out_max_idx), .out_count(s_out_count), .out_forced(s_out_forced)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: keeps the samples of the open frame and derives the
    // result from the whole list when the frame closes.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [4:0] mn;
        logic [4:0] mx;
        logic [3:0] mni;
        logic [3:0] mxi;
        logic [4:0] cnt;
        bit         forced;
    } res_t;

    int   frame_q[$];
    bit   m_valid = 1'b0;
    res_t m_u;
    res_t m_s;

    function automatic res_t frame_result(input bit sgn, input bit forced);
        res_t r;
        int   v, best_mn, best_mx;
        r = '{default: '0};
        best_mn = 0;
        best_mx = 0;
        r.forced = forced;
        r.cnt    = 5'(frame_q.size());
        for (int i = 0; i < frame_q.size(); i++) begin
            v = (sgn && frame_q[i] >= 16) ? frame_q[i] - 32 : frame_q[i];
            if (i == 0 || v < best_mn) begin
                best_mn = v; r.mn = 5'(frame_q[i]); r.mni = 4'(i);
            end
            if (i == 0 || v > best_mx) begin
                best_mx = v; r.mx = 5'(frame_q[i]); r.mxi = 4'(i);
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        m_valid = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid_u", u_out_valid, m_valid);
        chk("out_valid_s", s_out_valid, m_valid);
        if (m_valid) begin
            chk("min_u", u_out_min, m_u.mn);         chk("max_u", u_out_max, m_u.mx);
            chk("min_idx_u", u_out_min_idx, m_u.mni); chk("max_idx_u", u_out_max_idx, m_u.mxi);
            chk("count_u", u_out_count, m_u.cnt);     chk("forced_u", u_out_forced, m_u.forced);
            chk("min_s", s_out_min, m_s.mn);         chk("max_s", s_out_max, m_s.mx);
            chk("min_idx_s", s_out_min_idx, m_s.mni); chk("max_idx_s", s_out_max_idx, m_s.mxi);
            chk("count_s", s_out_count, m_s.cnt);     chk("forced_s", s_out_forced, m_s.forced);
        end
    endtask

    // One clock cycle: called at a falling edge, applies inputs, checks the
    // combinational in_ready, advances the model, and checks the registered
    // outputs at the next falling edge.
    task automatic do_cycle(input bit c, input bit v, input logic [4:0] d, input bit l, input bit r);
        bit exp_rdy, acc;
        clr = c; in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        exp_rdy = !(m_valid && !r);
        chk("in_ready_u", u_in_ready, exp_rdy);
        chk("in_ready_s", s_in_ready, exp_rdy);
        acc = v && exp_rdy && !c;
        if (m_valid && r) m_valid = 1'b0;
        if (c) begin
            frame_q.delete();
        end else if (acc) begin
            frame_q.push_back(int'(d));
            if (l || frame_q.size() == MAX_LEN) begin
                m_u = frame_result(1'b0, !l);
                m_s = frame_result(1'b1, !l);
                m_valid = 1'b1;
                frame_q.delete();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid_u"}, u_out_valid, 0);  chk({tag, "_valid_s"}, s_out_valid, 0);
        chk({tag, "_min"}, u_out_min, 0);        chk({tag, "_max"}, u_out_max, 0);
        chk({tag, "_min_idx"}, u_out_min_idx, 0); chk({tag, "_max_idx"}, u_out_max_idx, 0);
        chk({tag, "_count"}, u_out_count, 0);    chk({tag, "_forced"}, u_out_forced, 0);
        chk({tag, "_in_ready"}, u_in_ready, 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table with hand-derived expectations
    // ------------------------------------------------------------------------
    typedef struct {
        bit c, v; logic [4:0] d; bit l, r;
        bit ov;
        logic [4:0] umn, umx; logic [3:0] umi, umxi; logic [4:0] cnt; bit f;
        logic [4:0] smn, smx; logic [3:0] smi, smxi;
    } vec_t;

    function automatic vec_t mk(input bit c, input bit v, input logic [4:0] d, input bit l,
                                input bit r, input bit ov,
                                input logic [4:0] umn, input logic [4:0] umx,
                                input logic [3:0] umi, input logic [3:0] umxi,
                                input logic [4:0] cnt, input bit f,
                                input logic [4:0] smn, input logic [4:0] smx,
                                input logic [3:0] smi, input logic [3:0] smxi);
        vec_t t;
        t.c = c; t.v = v; t.d = d; t.l = l; t.r = r; t.ov = ov;
        t.umn = umn; t.umx = umx; t.umi = umi; t.umxi = umxi; t.cnt = cnt; t.f = f;
        t.smn = smn; t.smx = smx; t.smi = smi; t.smxi = smxi;
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        // Unsigned frame 3,7,1,7,1(last)
        tbl[0]  = mk(0, 1, 5'd3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 5'd7,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 5'd1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 5'd7,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 5'd1,  1, 1, 1, 1, 7, 2, 1, 5, 0, 1, 7, 2, 1);
        // Frame 5,-3,0,-16(last), started with no bubble
        tbl[5]  = mk(0, 1, 5'd5,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 5'd29, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 5'd0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 5'd16, 1, 1, 1, 0, 29, 2, 1, 4, 0, 16, 5, 3, 0);
        tbl[9]  = mk(0, 0, 5'd0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single-sample frame, then a back-to-back close with same-cycle drain
        tbl[10] = mk(0, 1, 5'd9,  1, 1, 1, 9, 9, 0, 0, 1, 0, 9, 9, 0, 0);
        tbl[11] = mk(0, 1, 5'd4,  1, 1, 1, 4, 4, 0, 0, 1, 0, 4, 4, 0, 0);
        tbl[12] = mk(0, 0, 5'd0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_cycle(tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk("tbl_valid", u_out_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk("tbl_min_u", u_out_min, tbl[i].umn);
                chk("tbl_max_u", u_out_max, tbl[i].umx);
                chk("tbl_min_idx_u", u_out_min_idx, tbl[i].umi);
                chk("tbl_max_idx_u", u_out_max_idx, tbl[i].umxi);
                chk("tbl_count_u", u_out_count, tbl[i].cnt);
                chk("tbl_forced_u", u_out_forced, tbl[i].f);
                chk("tbl_min_s", s_out_min, tbl[i].smn);
                chk("tbl_max_s", s_out_max, tbl[i].smx);
                chk("tbl_min_idx_s", s_out_min_idx, tbl[i].smi);
                chk("tbl_max_idx_s", s_out_max_idx, tbl[i].smxi);
            end
        end

        // Forced close at MAX_LEN, then a fresh frame
        for (int i = 0; i < 16; i++) do_cycle(0, 1, 5'(i), 0, 1);
        chk("forced_flag", u_out_forced, 1);
        chk("forced_count", u_out_count, 16);
        chk("forced_max", u_out_max, 15);
        chk("forced_max_idx", u_out_max_idx, 15);
        chk("forced_min_idx", u_out_min_idx, 0);
        do_cycle(0, 1, 5'd3, 1, 1);
        chk("after_forced_count", u_out_count, 1);
        chk("after_forced_flag", u_out_forced, 0);
        do_cycle(0, 0, 5'd0, 0, 1);

        // Back-pressure: result held, input stalled
        do_cycle(0, 1, 5'd10, 0, 1);
        do_cycle(0, 1, 5'd20, 1, 0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(0, 1, 5'd7, 1, 0);
            chk("bp_in_ready", u_in_ready, 0);
            chk("bp_min", u_out_min, 10);
            chk("bp_max", u_out_max, 20);
            chk("bp_count", u_out_count, 2);
            chk("bp_valid", u_out_valid, 1);
        end
        do_cycle(0, 0, 5'd0, 0, 1);
        chk("bp_drained", u_out_valid, 0);

        // clr after 3 samples (clr with a valid sample), then 9(last)
        do_cycle(0, 1, 5'd2, 0, 1);
        do_cycle(0, 1, 5'd8, 0, 1);
        do_cycle(0, 1, 5'd5, 0, 1);
        do_cycle(1, 1, 5'd1, 0, 1);
        do_cycle(0, 1, 5'd9, 1, 1);
        chk("clr_min", u_out_min, 9);
        chk("clr_max", u_out_max, 9);
        chk("clr_count", u_out_count, 1);

        // Asynchronous reset with a pending result
        do_cycle(0, 1, 5'd6, 1, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_pend");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-frame
        do_cycle(0, 1, 5'd17, 0, 1);
        do_cycle(0, 1, 5'd3, 0, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(0, 1, 5'd12, 1, 1);
        chk("rst_mid_count", u_out_count, 1);
        chk("rst_mid_min", u_out_min, 12);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            do_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                     5'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_minmax_stream
`default_nettype wire
